sram_wide_rd: RTL and testbench

//   Parametrised scratch SRAM for the NPU datapath: narrow write port, wide read port returning
//   RD_WORDS consecutive DATA_WIDTH entries per access. Read side uses valid/ready request and

---
 rtl/sram_wide_rd_pkg.sv | 24 ++
 rtl/sram_wide_rd_bank.sv | 36 +++
 rtl/sram_wide_rd.sv | 132 +++++++++++++
 tb/tb_sram_wide_rd.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sram_wide_rd_pkg.sv
// Shared parameters for the wide-read scratch SRAM and its neighbouring
// operand-buffer blocks: default geometry, wrap-mode encodings and the
// response-register state constants.
package sram_wide_rd_pkg;

  // Default geometry: 32-bit entries, 1024 deep, 64-bit read port (2 lanes).
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int N_ENTRIES_DEF    = 1024;
  localparam int DATA_WIDTH_O_DEF = 64;

  // Behaviour of read lanes that run past the last entry.
  localparam int WRAP_MODE_ZERO = 0;  // overflowing lanes read as zero
  localparam int WRAP_MODE_WRAP = 1;  // window wraps modulo N_ENTRIES

  // Response output register states.
  localparam logic [0:0] RSP_EMPTY = 1'b0;
  localparam logic [0:0] RSP_FULL  = 1'b1;

  // Number of entries returned per read access.
  function automatic int rd_words(input int dw, input int dwo);
    return dwo / dw;
  endfunction

endpackage

// File: rtl/sram_wide_rd_bank.sv
// One interleaved bank: DW x DEPTH array, one write and one synchronous
// read port. The read register only updates on re, so it holds the last
// read value while the consumer stalls.
import sram_wide_rd_pkg::*;

module sram_wide_rd_bank #(
  parameter int DW    = DATA_WIDTH_DEF,
  parameter int DEPTH = N_ENTRIES_DEF / 2,
  localparam int RAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic           re_i,
  input  logic [RAW-1:0] raddr_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Storage array write.
  // NOTE: the array has no reset branch so it maps onto RAM macros; only
  // the read register below is reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Synchronous read register; same-cycle write to the same row yields old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/sram_wide_rd.sv
// Scratch SRAM with a narrow auto-incrementing write port and a wide
// read port returning RD_WORDS consecutive entries per access. Entries are
// interleaved over RD_WORDS banks by their low address bits, so any window
// of RD_WORDS consecutive addresses touches every bank exactly once.
import sram_wide_rd_pkg::*;

module sram_wide_rd #(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int N_ENTRIES    = N_ENTRIES_DEF,
  parameter int DATA_WIDTH_O = DATA_WIDTH_O_DEF,
  parameter int WRAP_MODE    = WRAP_MODE_WRAP,
  localparam int AW          = $clog2(N_ENTRIES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_valid_i,
  input  logic                    wr_first_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  output logic                    wr_ready_o,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [AW-1:0]           rd_addr_i,
  output logic                    rd_data_valid_o,
  input  logic                    rd_data_ready_i,
  output logic [DATA_WIDTH_O-1:0] rd_data_o,
  output logic                    rd_oob_o
);

  localparam int RD_WORDS   = rd_words(DATA_WIDTH, DATA_WIDTH_O);
  localparam int BW         = $clog2(RD_WORDS);
  localparam int IW         = (BW > 0) ? BW : 1;
  localparam int BANK_DEPTH = N_ENTRIES / RD_WORDS;
  localparam int RAW        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam logic [AW-1:0] BANK_MASK = AW'(RD_WORDS - 1);

  logic            init_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   wr_target;
  logic [RAW-1:0]  wr_row;
  logic            wr_fire;
  logic            rd_fire;
  logic [0:0]      rsp_state_q;
  logic [AW-1:0]   base_q;
  logic [DATA_WIDTH-1:0] bank_rdata [RD_WORDS];

  // Does lane i of a window starting at base run past the last entry?
  function automatic logic lane_ovf(input logic [AW-1:0] base, input int i);
    logic [AW:0] a;
    a = {1'b0, base} + (AW+1)'(i);
    return a[AW];
  endfunction

  // Bank holding lane i of a window starting at base.
  function automatic logic [IW-1:0] bank_of(input logic [AW-1:0] base, input int i);
    return IW'((base + AW'(i)) & BANK_MASK);
  endfunction

  assign wr_ready_o      = init_q;
  assign wr_fire         = wr_valid_i && init_q;
  assign wr_target       = wr_first_i ? wr_addr_i : wr_ptr_q;
  assign wr_row          = RAW'(wr_target >> BW);
  assign rd_data_valid_o = (rsp_state_q == RSP_FULL);
  assign rd_req_ready_o  = init_q && (!rd_data_valid_o || rd_data_ready_i);
  assign rd_fire         = rd_req_valid_i && rd_req_ready_o;

  // Hold ports off for the first cycle after reset, then stay ready.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) init_q <= 1'b0;
    else         init_q <= 1'b1;
  end

  // Write burst pointer: next beat lands one past the last written entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      wr_ptr_q <= '0;
    else if (wr_fire) wr_ptr_q <= wr_target + AW'(1);
  end

  // Response register FSM; base address is kept for lane rotation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_state_q <= RSP_EMPTY;
      base_q      <= '0;
    end else if (rd_fire) begin
      rsp_state_q <= RSP_FULL;
      base_q      <= rd_addr_i;
    end else if (rd_data_ready_i) begin
      rsp_state_q <= RSP_EMPTY;
    end
  end

  // Banks: each one reads the single window entry that maps onto it.
  for (genvar k = 0; k < RD_WORDS; k++) begin : g_bank
    logic [AW-1:0]  lane_off;
    logic [AW-1:0]  lane_addr;
    logic [RAW-1:0] rd_row;

    assign lane_off  = (AW'(k) - rd_addr_i) & BANK_MASK;
    assign lane_addr = rd_addr_i + lane_off;
    assign rd_row    = RAW'(lane_addr >> BW);

    sram_wide_rd_bank #(
      .DW    (DATA_WIDTH),
      .DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_fire && ((wr_target & BANK_MASK) == AW'(k))),
      .waddr_i (wr_row),
      .wdata_i (wr_data_i),
      .re_i    (rd_fire),
      .raddr_i (rd_row),
      .rdata_o (bank_rdata[k])
    );
  end

  // Rotate bank outputs into lane order and flag lanes past the last entry.
  // NOTE: defaults assigned first so no path leaves an output unassigned
  // (which would infer a latch).
  always_comb begin
    rd_data_o = '0;
    rd_oob_o  = 1'b0;
    for (int i = 0; i < RD_WORDS; i++) begin
      if (lane_ovf(base_q, i)) rd_oob_o = 1'b1;
      if (!(lane_ovf(base_q, i) && WRAP_MODE == WRAP_MODE_ZERO))
        rd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[bank_of(base_q, i)];
    end
  end

endmodule

// File: tb/tb_sram_wide_rd.sv
// Directed bench for sram_wide_rd: two instances share all inputs, one in
// wrap mode and one in zero-fill mode, with default 32/1024/64 geometry.
module tb_sram_wide_rd;
  import sram_wide_rd_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wr_valid_i, wr_first_i;
  logic [9:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd_req_valid_i, rd_data_ready_i;
  logic [9:0]  rd_addr_i;

  logic        wr_ready_w, rd_req_ready_w, rd_data_valid_w, rd_oob_w;
  logic [63:0] rd_data_w;
  logic        wr_ready_z, rd_req_ready_z, rd_data_valid_z, rd_oob_z;
  logic [63:0] rd_data_z;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sram_wide_rd #(.WRAP_MODE(WRAP_MODE_WRAP)) u_dut_wrap (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_first_i(wr_first_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_w),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_w),
    .rd_addr_i(rd_addr_i), .rd_data_valid_o(rd_data_valid_w),
    .rd_data_ready_i(rd_data_ready_i), .rd_data_o(rd_data_w), .rd_oob_o(rd_oob_w)
  );

  sram_wide_rd #(.WRAP_MODE(WRAP_MODE_ZERO)) u_dut_zero (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_first_i(wr_first_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_z),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_z),
    .rd_addr_i(rd_addr_i), .rd_data_valid_o(rd_data_valid_z),
    .rd_data_ready_i(rd_data_ready_i), .rd_data_o(rd_data_z), .rd_oob_o(rd_oob_z)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response of both instances where the two modes must agree.
  task automatic check_rsp(input string tag, input logic valid, input logic [63:0] data,
                           input logic oob);
    check({tag, "_valid_w"}, 64'(rd_data_valid_w), 64'(valid));
    check({tag, "_valid_z"}, 64'(rd_data_valid_z), 64'(valid));
    check({tag, "_data_w"}, rd_data_w, data);
    check({tag, "_data_z"}, rd_data_z, data);
    check({tag, "_oob_w"}, 64'(rd_oob_w), 64'(oob));
    check({tag, "_oob_z"}, 64'(rd_oob_z), 64'(oob));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_beat(input logic first, input logic [9:0] addr, input logic [31:0] data);
    wr_valid_i = 1'b1;
    wr_first_i = first;
    wr_addr_i  = addr;
    wr_data_i  = data;
    tick();
    wr_valid_i = 1'b0;
    wr_first_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    wr_valid_i = 1'b0; wr_first_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_req_valid_i = 1'b0; rd_data_ready_i = 1'b1; rd_addr_i = '0;

    // Reset values
    tick(); tick();
    check("rst_wr_ready", 64'({wr_ready_w, wr_ready_z}), 64'b00);
    check("rst_rd_req_ready", 64'({rd_req_ready_w, rd_req_ready_z}), 64'b00);
    check_rsp("rst", 1'b0, 64'h0, 1'b0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_wr_ready", 64'({wr_ready_w, wr_ready_z}), 64'b11);
    check("post_rst_rd_req_ready", 64'({rd_req_ready_w, rd_req_ready_z}), 64'b11);

    // 1. Burst of 8 beats from 0x010, then aligned reads with 1-cycle latency
    write_beat(1'b1, 10'h010, 32'hA0);
    for (int i = 1; i < 8; i++) write_beat(1'b0, 10'h000, 32'hA0 + 32'(i));
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h010;
    check_rsp("lat_before", 1'b0, 64'h0, 1'b0);
    tick();
    check_rsp("rd_010", 1'b1, 64'h000000A1_000000A0, 1'b0);
    rd_addr_i = 10'h012;
    tick();
    check_rsp("rd_012", 1'b1, 64'h000000A3_000000A2, 1'b0);

    // 2. Unaligned window
    rd_addr_i = 10'h011;
    tick();
    check_rsp("rd_011", 1'b1, 64'h000000A2_000000A1, 1'b0);
    rd_req_valid_i = 1'b0;
    tick();
    check_rsp("drain_hold", 1'b0, 64'h000000A2_000000A1, 1'b0);

    // 3. Window across the top; the 0x66 beat also exercises pointer wrap
    write_beat(1'b1, 10'h3FF, 32'h55);
    write_beat(1'b0, 10'h000, 32'h66);
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h3FF;
    tick();
    check("wrap_data_w", rd_data_w, 64'h00000066_00000055);
    check("wrap_data_z", rd_data_z, 64'h00000000_00000055);
    check("wrap_oob_w", 64'(rd_oob_w), 64'd1);
    check("wrap_oob_z", 64'(rd_oob_z), 64'd1);
    rd_req_valid_i = 1'b0;
    tick();

    // 4. Backpressure: three requests, consumer stalls 4 cycles after the first
    rd_data_ready_i = 1'b0;
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h010;
    tick();
    check_rsp("bp_a", 1'b1, 64'h000000A1_000000A0, 1'b0);
    rd_addr_i = 10'h012;
    for (int i = 0; i < 4; i++) begin
      check("bp_req_ready", 64'({rd_req_ready_w, rd_req_ready_z}), 64'b00);
      tick();
      check_rsp("bp_stall", 1'b1, 64'h000000A1_000000A0, 1'b0);
    end
    rd_data_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'({rd_req_ready_w, rd_req_ready_z}), 64'b11);
    tick();
    check_rsp("bp_b", 1'b1, 64'h000000A3_000000A2, 1'b0);
    rd_addr_i = 10'h014;
    tick();
    check_rsp("bp_c", 1'b1, 64'h000000A5_000000A4, 1'b0);
    rd_req_valid_i = 1'b0;
    tick();
    check_rsp("bp_empty", 1'b0, 64'h000000A5_000000A4, 1'b0);

    // 5. Same-cycle write and read of 0x020: read-before-write
    write_beat(1'b1, 10'h020, 32'h11);
    write_beat(1'b0, 10'h000, 32'h77);
    wr_valid_i = 1'b1; wr_first_i = 1'b1; wr_addr_i = 10'h020; wr_data_i = 32'h22;
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h020;
    tick();
    wr_valid_i = 1'b0; wr_first_i = 1'b0;
    check_rsp("coll_old", 1'b1, 64'h00000077_00000011, 1'b0);
    tick();
    check_rsp("coll_new", 1'b1, 64'h00000077_00000022, 1'b0);
    rd_req_valid_i = 1'b0;
    tick();

    // 6. Reset while a response is stalled and a write beat is pending
    write_beat(1'b1, 10'h030, 32'hC3);
    write_beat(1'b0, 10'h000, 32'hC4);
    rd_data_ready_i = 1'b0;
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h030;
    tick();
    check_rsp("rst6_stalled", 1'b1, 64'h000000C4_000000C3, 1'b0);
    wr_valid_i = 1'b1; wr_first_i = 1'b1; wr_addr_i = 10'h030; wr_data_i = 32'hBAD;
    #2 rst_ni = 1'b0;
    #1;
    check_rsp("rst6_async", 1'b0, 64'h0, 1'b0);
    check("rst6_wr_ready", 64'({wr_ready_w, wr_ready_z}), 64'b00);
    wr_valid_i = 1'b0; wr_first_i = 1'b0;
    rd_req_valid_i = 1'b0; rd_data_ready_i = 1'b1;
    tick();
    rst_ni = 1'b1;
    tick();
    check_rsp("rst6_no_stale", 1'b0, 64'h0, 1'b0);
    write_beat(1'b0, 10'h000, 32'h99);
    write_beat(1'b0, 10'h000, 32'hAA);
    rd_req_valid_i = 1'b1; rd_addr_i = 10'h000;
    tick();
    check_rsp("rst6_ptr_zero", 1'b1, 64'h000000AA_00000099, 1'b0);
    rd_addr_i = 10'h030;
    tick();
    check_rsp("rst6_no_write", 1'b1, 64'h000000C4_000000C3, 1'b0);
    rd_req_valid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
